// File: rtl/inj_stream_arbiter.sv
// rtl/inj_stream_arbiter.sv - packet-granular round-robin arbiter onto one injector port
//
// Shares a single injector flit input among NUM_SRC stream sources. A packet is a
// header flit carrying N followed by N payload flits; the grant is locked for
// exactly N+1 transfers and then released for a fresh round-robin scan.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous reset, active-high
//   src_tx_i      per-source flit valid
//   src_data_i    per-source flit, source k at [k*FLIT_SIZE +: FLIT_SIZE]
//   src_credit_o  per-source credit (ready), only the owner can see credit
//   inj_tx_o      flit valid to injector
//   inj_data_o    flit to injector
//   inj_credit_i  injector credit
//   grant_o       one-hot current owner, 0 when idle
//   busy_o        grant held (HEAD or BODY)
module inj_stream_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int FLIT_SIZE = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_SRC-1:0]             src_tx_i,
    input  logic [NUM_SRC*FLIT_SIZE-1:0]   src_data_i,
    output logic [NUM_SRC-1:0]             src_credit_o,
    output logic                           inj_tx_o,
    output logic [FLIT_SIZE-1:0]           inj_data_o,
    input  logic                           inj_credit_i,
    output logic [NUM_SRC-1:0]             grant_o,
    output logic                           busy_o
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t                 state_q;
    logic [PTR_W-1:0]       ptr_q;
    logic [FLIT_SIZE-1:0]   cnt_q;

    logic                   active;
    logic                   sel_tx;
    logic [FLIT_SIZE-1:0]   sel_data;
    logic                   xfer;

    logic                   req_found;
    logic [PTR_W-1:0]       req_idx;
    logic [PTR_W-1:0]       scan_idx;

    // ptr_q always names the owner while busy, so it doubles as the mux select.
    assign active   = (state_q != IDLE);
    assign sel_tx   = src_tx_i[ptr_q];
    assign sel_data = src_data_i[ptr_q*FLIT_SIZE +: FLIT_SIZE];
    assign xfer     = active && sel_tx && inj_credit_i;

    assign inj_tx_o     = active && sel_tx;
    assign inj_data_o   = active ? sel_data : '0;
    assign src_credit_o = (active && inj_credit_i) ? grant_o : '0;

    // Round-robin scan from ptr+1. Iterating from the far end downward lets the
    // nearest requester overwrite any farther one, giving first-match priority.
    always_comb begin
        req_found = 1'b0;
        req_idx   = ptr_q;
        scan_idx  = ptr_q;
        for (int i = NUM_SRC; i >= 1; i--) begin
            scan_idx = PTR_W'((int'(ptr_q) + i) % NUM_SRC);
            if (src_tx_i[scan_idx]) begin
                req_found = 1'b1;
                req_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= PTR_W'(NUM_SRC - 1);
            cnt_q   <= '0;
            grant_o <= '0;
            busy_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_found) begin
                        grant_o <= {{(NUM_SRC-1){1'b0}}, 1'b1} << req_idx;
                        ptr_q   <= req_idx;
                        busy_o  <= 1'b1;
                        state_q <= HEAD;
                    end
                end
                HEAD: begin
                    if (xfer) begin
                        cnt_q <= sel_data;
                        if (sel_data == '0) begin
                            grant_o <= '0;
                            busy_o  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= BODY;
                        end
                    end
                end
                BODY: begin
                    // Release at 1 so the counter never wraps, even for an
                    // all-ones header.
                    if (xfer) begin
                        cnt_q <= cnt_q - FLIT_SIZE'(1);
                        if (cnt_q == FLIT_SIZE'(1)) begin
                            grant_o <= '0;
                            busy_o  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    grant_o <= '0;
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
